// File: rtl/div_wb_queue.sv
// rtl/div_wb_queue.sv - divide result staging FIFO in front of the shared register write port
// Optional same-cycle bypass of an empty queue: define DIVWB_BYPASS_EN.
module div_wb_queue #(
    parameter int BW    = 32,
    parameter int LGREG = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_div_wr,
    input  logic [LGREG-1:0] i_div_reg,
    input  logic             i_div_valid,
    input  logic             i_div_err,
    input  logic [BW-1:0]    i_div_quotient,
    input  logic [3:0]       i_div_flags,
    input  logic             i_wb_ready,
    output logic             o_wb_valid,
    output logic [LGREG-1:0] o_wb_reg,
    output logic [BW-1:0]    o_wb_data,
    output logic [3:0]       o_wb_flags,
    output logic             o_err,
    output logic             o_div_stall,
    output logic             o_pending,
    output logic [LGREG-1:0] o_pending_reg
);
    localparam int EW = 1 + LGREG + BW + 4;

    logic [EW-1:0]    mem [0:1];
    logic [1:0]       wr_ptr, rd_ptr, count;
    logic             r_flight;
    logic [LGREG-1:0] r_flight_reg;
    logic             r_err;

    logic [EW-1:0]    head, tail;
    logic             head_err, q_valid, err_pop, pop, push, res_ok, bypass;
    logic [2:0]       occupancy;

    assign head     = mem[rd_ptr[0]];
    assign tail     = mem[~wr_ptr[0]];
    assign head_err = head[EW-1];
    assign q_valid  = (count != 2'd0) && !head_err;
    assign err_pop  = (count != 2'd0) && head_err;
    assign pop      = (q_valid && i_wb_ready) || err_pop;

    // A result with no tracked divide in flight, or arriving under reset, is dropped.
    assign res_ok   = i_div_valid && r_flight && !i_reset;

`ifdef DIVWB_BYPASS_EN
    assign bypass   = res_ok && !i_div_err && (count == 2'd0);
`else
    assign bypass   = 1'b0;
`endif

    assign push      = res_ok && !(bypass && i_wb_ready);
    assign occupancy = {1'b0, count} + {2'b00, r_flight};

    always_comb begin
        o_wb_valid = 1'b0;
        o_wb_reg   = '0;
        o_wb_data  = '0;
        o_wb_flags = '0;
        if (bypass) begin
            o_wb_valid = 1'b1;
            o_wb_reg   = r_flight_reg;
            o_wb_data  = i_div_quotient;
            o_wb_flags = i_div_flags;
        end else if (count != 2'd0) begin
            o_wb_valid = q_valid;
            o_wb_reg   = head[EW-2 -: LGREG];
            o_wb_data  = head[BW+3:4];
            o_wb_flags = head[3:0];
        end
    end

    always_comb begin
        o_pending_reg = '0;
        if (r_flight)
            o_pending_reg = r_flight_reg;
        else if (count != 2'd0)
            o_pending_reg = tail[EW-2 -: LGREG];
    end

    assign o_err       = r_err;
    assign o_div_stall = i_reset || (occupancy >= 3'd2);
    assign o_pending   = r_flight || (count != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            r_flight     <= 1'b0;
            r_flight_reg <= '0;
            r_err        <= 1'b0;
            mem[0]       <= '0;
            mem[1]       <= '0;
        end else begin
            if (i_div_wr) begin
                r_flight     <= 1'b1;
                r_flight_reg <= i_div_reg;
            end else if (i_div_valid) begin
                r_flight     <= 1'b0;
            end
            if (push) begin
                mem[wr_ptr[0]] <= {i_div_err, r_flight_reg, i_div_quotient, i_div_flags};
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
            r_err <= err_pop;
        end
    end
endmodule

// File: tb/tb_div_wb_queue.sv
// tb/tb_div_wb_queue.sv - directed self-checking bench for div_wb_queue
module tb_div_wb_queue;
    logic        i_clk, i_reset;
    logic        i_div_wr, i_div_valid, i_div_err, i_wb_ready;
    logic [4:0]  i_div_reg;
    logic [31:0] i_div_quotient;
    logic [3:0]  i_div_flags;
    logic        o_wb_valid, o_err, o_div_stall, o_pending;
    logic [4:0]  o_wb_reg, o_pending_reg;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_flags;

    int checks = 0;
    int errors = 0;

    div_wb_queue #(.BW(32), .LGREG(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_div_wr(i_div_wr), .i_div_reg(i_div_reg),
        .i_div_valid(i_div_valid), .i_div_err(i_div_err),
        .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
        .i_wb_ready(i_wb_ready),
        .o_wb_valid(o_wb_valid), .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data),
        .o_wb_flags(o_wb_flags), .o_err(o_err), .o_div_stall(o_div_stall),
        .o_pending(o_pending), .o_pending_reg(o_pending_reg)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic result(input logic [31:0] q, input logic [3:0] f, input logic e);
        i_div_valid = 1'b1; i_div_quotient = q; i_div_flags = f; i_div_err = e;
    endtask

    task automatic idle_result();
        i_div_valid = 1'b0; i_div_quotient = '0; i_div_flags = '0; i_div_err = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_div_wr = 1'b0; i_div_reg = '0; i_wb_ready = 1'b0;
        idle_result();

        // reset
        repeat (3) tick();
        check("rst_stall", o_div_stall, 1);
        check("rst_valid", o_wb_valid, 0);
        check("rst_err", o_err, 0);
        check("rst_pending", o_pending, 0);
        check("rst_pending_reg", o_pending_reg, 0);
        check("rst_wb_reg", o_wb_reg, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_wb_flags", o_wb_flags, 0);
        i_reset = 1'b0;
        #1;
        check("post_rst_stall", o_div_stall, 0);

        // single divide to reg 7, ready high
        i_div_wr = 1'b1; i_div_reg = 5'd7;
        tick();
        i_div_wr = 1'b0;
        #1;
        check("flight_pending", o_pending, 1);
        check("flight_pending_reg", o_pending_reg, 7);
        tick(); tick();
        result(32'h5, 4'h0, 1'b0); i_wb_ready = 1'b1;
        #1;
`ifdef DIVWB_BYPASS_EN
        check("byp_valid", o_wb_valid, 1);
        check("byp_reg", o_wb_reg, 7);
        check("byp_data", o_wb_data, 32'h5);
        tick();
        idle_result();
        #1;
        check("byp_after_valid", o_wb_valid, 0);
`else
        check("lat_valid_early", o_wb_valid, 0);
        tick();
        idle_result();
        #1;
        check("one_valid", o_wb_valid, 1);
        check("one_reg", o_wb_reg, 7);
        check("one_data", o_wb_data, 32'h5);
        tick();
        #1;
        check("one_after_valid", o_wb_valid, 0);
`endif
        check("one_pending_fall", o_pending, 0);
        i_wb_ready = 1'b0;

        // two divides queued with ready low
        i_div_wr = 1'b1; i_div_reg = 5'd3;
        tick();
        i_div_wr = 1'b0;
        tick();
        result(32'h33, 4'h1, 1'b0);
        tick();
        idle_result();
        #1;
        check("q1_stall", o_div_stall, 0);
        check("q1_head_reg", o_wb_reg, 3);
        i_div_wr = 1'b1; i_div_reg = 5'd9;
        tick();
        i_div_wr = 1'b0;
        #1;
        check("q1f_stall", o_div_stall, 1);
        check("q1f_pending_reg", o_pending_reg, 9);
        result(32'h99, 4'h2, 1'b0);
        tick();
        idle_result();
        #1;
        check("q2_stall", o_div_stall, 1);
        check("q2_pending_reg", o_pending_reg, 9);
        check("q2_head_reg", o_wb_reg, 3);
        result(32'hDEAD, 4'hF, 1'b0);
        tick();
        idle_result();
        #1;
        check("q2_nopush_tail", o_pending_reg, 9);
        check("q2_nopush_head", o_wb_data, 32'h33);
        i_wb_ready = 1'b1;
        #1;
        check("ret3_valid", o_wb_valid, 1);
        check("ret3_reg", o_wb_reg, 3);
        check("ret3_data", o_wb_data, 32'h33);
        check("ret3_flags", o_wb_flags, 4'h1);
        tick();
        check("ret9_valid", o_wb_valid, 1);
        check("ret9_reg", o_wb_reg, 9);
        check("ret9_data", o_wb_data, 32'h99);
        check("ret9_flags", o_wb_flags, 4'h2);
        check("ret9_stall", o_div_stall, 0);
        tick();
        check("drain_valid", o_wb_valid, 0);
        check("drain_pending", o_pending, 0);
        i_wb_ready = 1'b0;

        // error result to reg 4
        i_div_wr = 1'b1; i_div_reg = 5'd4;
        tick();
        i_div_wr = 1'b0;
        result(32'h0, 4'h0, 1'b1);
        #1;
        check("errN_valid", o_wb_valid, 0);
        tick();
        idle_result();
        #1;
        check("errN1_valid", o_wb_valid, 0);
        check("errN1_reg", o_wb_reg, 4);
        check("errN1_err", o_err, 0);
        check("errN1_pending", o_pending, 1);
        tick();
        check("errN2_err", o_err, 1);
        check("errN2_valid", o_wb_valid, 0);
        check("errN2_pending", o_pending, 0);
        tick();
        check("errN3_err", o_err, 0);

        // reset with one queued entry and one in flight
        i_div_wr = 1'b1; i_div_reg = 5'd11;
        tick();
        i_div_wr = 1'b0;
        result(32'h11, 4'h0, 1'b0);
        tick();
        idle_result();
        i_div_wr = 1'b1; i_div_reg = 5'd12;
        tick();
        i_div_wr = 1'b0;
        #1;
        check("pre_rst_pending_reg", o_pending_reg, 12);
        i_reset = 1'b1;
        result(32'h12, 4'h0, 1'b0);
        tick();
        i_reset = 1'b0;
        idle_result();
        #1;
        check("mid_rst_pending", o_pending, 0);
        check("mid_rst_valid", o_wb_valid, 0);
        check("mid_rst_stall", o_div_stall, 0);
        result(32'h77, 4'h0, 1'b0);
        #1;
        check("orphan_valid_now", o_wb_valid, 0);
        tick();
        idle_result();
        #1;
        check("orphan_valid", o_wb_valid, 0);
        check("orphan_pending", o_pending, 0);

        // pop and push in the same cycle with count 1
        i_div_wr = 1'b1; i_div_reg = 5'd1;
        tick();
        i_div_wr = 1'b0;
        result(32'hA1, 4'h3, 1'b0);
        tick();
        idle_result();
        i_div_wr = 1'b1; i_div_reg = 5'd2;
        tick();
        i_div_wr = 1'b0;
        #1;
        check("pp_head_reg", o_wb_reg, 1);
        result(32'hB2, 4'h5, 1'b0); i_wb_ready = 1'b1;
        tick();
        idle_result(); i_wb_ready = 1'b0;
        #1;
        check("pp_valid", o_wb_valid, 1);
        check("pp_reg", o_wb_reg, 2);
        check("pp_data", o_wb_data, 32'hB2);
        check("pp_flags", o_wb_flags, 4'h5);
        check("pp_pending_reg", o_pending_reg, 2);
        check("pp_stall", o_div_stall, 0);
        i_wb_ready = 1'b1;
        tick();
        check("pp_drain_valid", o_wb_valid, 0);
        check("pp_drain_pending", o_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
